// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, funct3 codes, FSM states and access-size helpers for the
// MEM-stage data-memory access engine.
package mem_access_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Undefined funct3 codes fall back to a full-word access.
  function automatic size_t access_size(input logic [2:0] funct3, input logic is_load);
    size_t sz;
    sz = SZ_WORD;
    if (is_load) begin
      if (funct3 == F3_LB || funct3 == F3_LBU) sz = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
    end else begin
      if (funct3 == F3_SB) sz = SZ_BYTE;
      else if (funct3 == F3_SH) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (sz == SZ_HALF) mis = off[0];
    else if (sz == SZ_WORD) mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory port between the MEM stage and DRAM.
// Handshake: req stays high with addr/we/wdata/wstrb stable until the cycle ack
// is high; ack completes the transfer and rdata is valid in that same cycle.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction with
// sign/zero extension, all from funct3 and the byte offset.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rd2,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb     = 4'b1111;
    wdata     = rd2;
    load_data = '0;
    shifted   = rdata >> {off, 3'b000};

    case (access_size(funct3, 1'b0))
      SZ_BYTE: begin
        wstrb = 4'b0001 << off;
        wdata = {4{rd2[7:0]}};
      end
      SZ_HALF: begin
        wstrb = 4'b0011 << off;
        wdata = {2{rd2[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = rd2;
      end
    endcase

    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: issues one DRAM access per load/store,
// stalls the pipeline until it completes, and returns formatted load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               inst_i,
  input  logic [31:0]               alu_c_i,
  input  logic [31:0]               rD2_i,
  input  logic                      ram_we_i,
  mem_access_unit_if.master         dram,
  output logic                      mem_stall_o,
  output logic [31:0]               load_data_o,
  output logic                      load_valid_o,
  output logic                      misalign_o,
  output logic                      timeout_o,
  output state_t                    dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] rd2_q;
  logic        we_q, load_q, mis_q, to_q;
  logic [31:0] ld_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, access, mis;
  logic        stall, req;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata, fmt_load;
  logic        unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE) && ram_we_i;
  assign access      = is_load || is_store;
  assign mis         = is_misaligned(access_size(funct3, is_load), alu_c_i[1:0]);

  // Formatting works from the latched access so the bus stays stable while the
  // pipeline inputs are frozen or changing.
  mem_lane_align u_align (
    .funct3    (f3_q),
    .off       (off_q),
    .rd2       (rd2_q),
    .rdata     (dram.rdata),
    .wstrb     (fmt_wstrb),
    .wdata     (fmt_wdata),
    .load_data (fmt_load)
  );

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    req     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (access) begin
          stall   = 1'b1;
          state_n = mis ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dram.ack || cnt == CNT_MAX) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      off_q  <= '0;
      f3_q   <= '0;
      rd2_q  <= '0;
      we_q   <= 1'b0;
      load_q <= 1'b0;
      mis_q  <= 1'b0;
      to_q   <= 1'b0;
      ld_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (access) begin
            load_q <= is_load;
            mis_q  <= mis;
            to_q   <= 1'b0;
            cnt    <= '0;
            if (mis) begin
              ld_q <= '0;
            end else begin
              addr_q <= alu_c_i[31:2];
              off_q  <= alu_c_i[1:0];
              f3_q   <= funct3;
              rd2_q  <= rD2_i;
              we_q   <= is_store;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (dram.ack) begin
            if (load_q) ld_q <= fmt_load;
          end else if (cnt == CNT_MAX) begin
            to_q <= 1'b1;
            ld_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with rst lets the stall release asynchronously even while the
  // frozen EX/MEM register still presents an access.
  assign mem_stall_o  = stall && !rst;
  assign dram.req     = req;
  assign dram.we      = we_q;
  assign dram.addr    = {addr_q, 2'b00};
  assign dram.wdata   = fmt_wdata;
  assign dram.wstrb   = we_q ? fmt_wstrb : 4'b0000;
  assign load_data_o  = ld_q;
  assign load_valid_o = (state == ST_DONE) && load_q;
  assign misalign_o   = (state == ST_DONE) && mis_q;
  assign timeout_o    = (state == ST_DONE) && to_q;
  assign dbg_state_o  = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset-in-flight sequence and
// randomized accesses checked against an arithmetic reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    int          ack_after;
    logic [31:0] rdata;
    int          exp_stall;
    int          exp_req;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_mis;
    logic        exp_to;
    logic        exp_lv;
    logic [31:0] exp_ld;
  } vec_t;

  typedef struct {
    int          stall_n;
    int          req_n;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  bwstrb;
    logic        bwe;
    logic        stable;
    logic        early;
    logic        mis;
    logic        to;
    logic        lv;
    logic [31:0] ld;
    state_t      st;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, alu_c_i, rD2_i;
  logic        ram_we_i;
  logic        mem_stall_o, load_valid_o, misalign_o, timeout_o;
  logic [31:0] load_data_o;
  state_t      dbg_state;

  mem_access_unit_if dram_bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .alu_c_i      (alu_c_i),
    .rD2_i        (rD2_i),
    .ram_we_i     (ram_we_i),
    .dram         (dram_bus.master),
    .mem_stall_o  (mem_stall_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .misalign_o   (misalign_o),
    .timeout_o    (timeout_o),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    r[6:0]   = op;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [31:0] inst, addr, data, input logic we,
                               input int ack_after, input logic [31:0] rdata,
                               input int stall_n, req_n, input logic [3:0] wstrb,
                               input logic [31:0] wdata, baddr, input logic bwe,
                               input logic m, t, lv, input logic [31:0] ld);
    vec_t v;
    v.inst = inst; v.addr = addr; v.data = data; v.we = we;
    v.ack_after = ack_after; v.rdata = rdata;
    v.exp_stall = stall_n; v.exp_req = req_n; v.exp_wstrb = wstrb;
    v.exp_wdata = wdata; v.exp_addr = baddr; v.exp_we = bwe;
    v.exp_mis = m; v.exp_to = t; v.exp_lv = lv; v.exp_ld = ld;
    return v;
  endfunction

  // Reference model: byte counts, modulo arithmetic and masks.
  function automatic vec_t model(input logic [31:0] inst, addr, data, input logic we,
                                 input int ack_after, input logic [31:0] rdata);
    vec_t v;
    int nbytes, off, busy;
    logic is_ld, is_st, sgn, tmo;
    logic [31:0] mask, val;
    v = mkv(inst, addr, data, we, ack_after, rdata, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    is_ld = (inst[6:0] == 7'h03);
    is_st = (inst[6:0] == 7'h23) && we;
    if (!is_ld && !is_st) return v;
    nbytes = 4;
    if (is_ld && (inst[14:12] == 3'd0 || inst[14:12] == 3'd4)) nbytes = 1;
    if (is_ld && (inst[14:12] == 3'd1 || inst[14:12] == 3'd5)) nbytes = 2;
    if (is_st && inst[14:12] == 3'd0) nbytes = 1;
    if (is_st && inst[14:12] == 3'd1) nbytes = 2;
    sgn  = is_ld && (inst[14:12] == 3'd0 || inst[14:12] == 3'd1);
    off  = int'(addr % 4);
    v.exp_lv = is_ld;
    if (off % nbytes != 0) begin
      v.exp_stall = 1;
      v.exp_mis   = 1'b1;
      return v;
    end
    tmo  = !(ack_after >= 1 && ack_after <= TO);
    busy = tmo ? TO : ack_after;
    v.exp_to    = tmo;
    v.exp_stall = busy + 1;
    v.exp_req   = busy;
    v.exp_addr  = addr - off;
    v.exp_we    = is_st;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (is_st) begin
      v.exp_wstrb = 4'(((1 << nbytes) - 1) << off);
      if (nbytes == 1) v.exp_wdata = (data & mask) * 32'h0101_0101;
      else if (nbytes == 2) v.exp_wdata = (data & mask) * 32'h0001_0001;
      else v.exp_wdata = data;
    end
    if (is_ld && !tmo) begin
      val = (rdata >> (8 * off)) & mask;
      if (sgn && val[8 * nbytes - 1]) val = val | ~mask;
      v.exp_ld = val;
    end
    return v;
  endfunction

  // Drives one instruction into the EX/MEM inputs, plays the DRAM responder,
  // and returns what was seen up to the first non-stalled cycle.
  task automatic run_access(input vec_t v, output obs_t o);
    o.stall_n = 0; o.req_n = 0; o.baddr = 0; o.bwdata = 0; o.bwstrb = 0; o.bwe = 0;
    o.stable = 1'b1; o.early = 1'b0; o.mis = 0; o.to = 0; o.lv = 0; o.ld = 0; o.st = ST_IDLE;
    @(posedge clk); #1;
    inst_i = v.inst; alu_c_i = v.addr; rD2_i = v.data; ram_we_i = v.we;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (dram_bus.req) begin
        o.req_n++;
        if (o.req_n == 1) begin
          o.baddr = dram_bus.addr; o.bwdata = dram_bus.wdata;
          o.bwstrb = dram_bus.wstrb; o.bwe = dram_bus.we;
        end else if (o.baddr !== dram_bus.addr || o.bwdata !== dram_bus.wdata ||
                     o.bwstrb !== dram_bus.wstrb || o.bwe !== dram_bus.we) begin
          o.stable = 1'b0;
        end
        dram_bus.ack   = (o.req_n == v.ack_after);
        dram_bus.rdata = (o.req_n == v.ack_after) ? v.rdata : $urandom;
      end else begin
        dram_bus.ack   = 1'($urandom_range(0, 1));
        dram_bus.rdata = $urandom;
      end
      #3;
      if (mem_stall_o) begin
        o.stall_n++;
        if (misalign_o || timeout_o || load_valid_o) o.early = 1'b1;
      end else begin
        o.mis = misalign_o; o.to = timeout_o; o.lv = load_valid_o;
        o.ld = load_data_o; o.st = dbg_state;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_obs(input string n, input vec_t v, input obs_t o);
    chk({n, " stall_cycles"}, o.stall_n, v.exp_stall);
    chk({n, " req_cycles"}, o.req_n, v.exp_req);
    chk({n, " misalign"}, o.mis, v.exp_mis);
    chk({n, " timeout"}, o.to, v.exp_to);
    chk({n, " load_valid"}, o.lv, v.exp_lv);
    chk({n, " early_pulse"}, o.early, 1'b0);
    if (v.exp_stall > 0) chk({n, " done_state"}, o.st, ST_DONE);
    if (v.exp_req > 0) begin
      chk({n, " addr"}, o.baddr, v.exp_addr);
      chk({n, " we"}, o.bwe, v.exp_we);
      chk({n, " wstrb"}, o.bwstrb, v.exp_wstrb);
      chk({n, " bus_stable"}, o.stable, 1'b1);
      if (v.exp_we) chk({n, " wdata"}, o.bwdata, v.exp_wdata);
    end
  endtask

  initial begin
    obs_t o;
    vec_t v;
    int sel, r;
    logic [6:0] op;

    rst = 1'b1; inst_i = 0; alu_c_i = 0; rD2_i = 0; ram_we_i = 0;
    dram_bus.ack = 1'b0; dram_bus.rdata = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst req", dram_bus.req, 1'b0);
    chk("rst stall", mem_stall_o, 1'b0);
    chk("rst wstrb", dram_bus.wstrb, 4'h0);
    chk("rst addr", dram_bus.addr, 32'h0);
    chk("rst we", dram_bus.we, 1'b0);
    chk("rst load_data", load_data_o, 32'h0);
    chk("rst pulses", {load_valid_o, misalign_o, timeout_o}, 3'b000);
    chk("rst state", dbg_state, ST_IDLE);
    @(negedge clk); rst = 1'b0;

    vecs[0]  = mkv(mk_inst(3'd2, 7'h23), 32'h100, 32'h1234_5678, 1, 3, 0, 4, 3, 4'hF, 32'h1234_5678, 32'h100, 1, 0, 0, 0, 0);
    vecs[1]  = mkv(mk_inst(3'd0, 7'h23), 32'h103, 32'h0000_00AB, 1, 2, 0, 3, 2, 4'h8, 32'hABAB_ABAB, 32'h100, 1, 0, 0, 0, 0);
    vecs[2]  = mkv(mk_inst(3'd0, 7'h03), 32'h201, 0, 0, 1, 32'h0000_8000, 2, 1, 4'h0, 0, 32'h200, 0, 0, 0, 1, 32'hFFFF_FF80);
    vecs[3]  = mkv(mk_inst(3'd4, 7'h03), 32'h201, 0, 0, 1, 32'h0000_8000, 2, 1, 4'h0, 0, 32'h200, 0, 0, 0, 1, 32'h0000_0080);
    vecs[4]  = mkv(mk_inst(3'd5, 7'h03), 32'h202, 0, 0, 2, 32'hBEEF_0000, 3, 2, 4'h0, 0, 32'h200, 0, 0, 0, 1, 32'h0000_BEEF);
    vecs[5]  = mkv(mk_inst(3'd2, 7'h03), 32'h1002, 0, 0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 1, 0, 1, 32'h0);
    vecs[6]  = mkv(mk_inst(3'd2, 7'h03), 32'h300, 0, 0, 0, 0, 17, 16, 4'h0, 0, 32'h300, 0, 0, 1, 1, 32'h0);
    vecs[7]  = mkv(mk_inst(3'd0, 7'h33), 32'h104, 0, 1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mkv(mk_inst(3'd2, 7'h23), 32'h108, 32'hDEAD, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mkv(mk_inst(3'd1, 7'h23), 32'h102, 32'h0000_CAFE, 1, 1, 0, 2, 1, 4'hC, 32'hCAFE_CAFE, 32'h100, 1, 0, 0, 0, 0);
    vecs[10] = mkv(mk_inst(3'd1, 7'h03), 32'h006, 0, 0, 1, 32'h8001_0000, 2, 1, 4'h0, 0, 32'h004, 0, 0, 0, 1, 32'hFFFF_8001);
    vecs[11] = mkv(mk_inst(3'd1, 7'h23), 32'h101, 32'h1111, 1, 1, 0, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0);
    vecs[12] = mkv(mk_inst(3'd2, 7'h03), 32'h400, 0, 0, 16, 32'hCAFE_F00D, 17, 16, 4'h0, 0, 32'h400, 0, 0, 0, 1, 32'hCAFE_F00D);
    vecs[13] = mkv(mk_inst(3'd7, 7'h23), 32'h10C, 32'h8765_4321, 1, 1, 0, 2, 1, 4'hF, 32'h8765_4321, 32'h10C, 1, 0, 0, 0, 0);
    vecs[14] = mkv(mk_inst(3'd3, 7'h03), 32'h201, 0, 0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 1, 0, 1, 32'h0);

    for (int i = 0; i < 15; i++) begin
      run_access(vecs[i], o);
      check_obs($sformatf("vec%0d", i), vecs[i], o);
      if (vecs[i].exp_lv) chk($sformatf("vec%0d load_data", i), o.ld, vecs[i].exp_ld);
    end

    // Reset during the second BUSY cycle, with the access still presented.
    @(posedge clk); #1;
    inst_i = mk_inst(3'd2, 7'h03); alu_c_i = 32'h40; ram_we_i = 1'b0;
    dram_bus.ack = 1'b0;
    @(posedge clk); #1;
    chk("rstbusy req_first", dram_bus.req, 1'b1);
    @(posedge clk); #2;
    chk("rstbusy req_second", dram_bus.req, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstbusy req_drop", dram_bus.req, 1'b0);
    chk("rstbusy stall_drop", mem_stall_o, 1'b0);
    chk("rstbusy state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    chk("rstbusy no_pulse", {load_valid_o, misalign_o, timeout_o}, 3'b000);
    inst_i = mk_inst(3'd0, 7'h13);
    @(posedge clk); #1;
    rst = 1'b0;
    v = mkv(mk_inst(3'd2, 7'h03), 32'h40, 0, 0, 2, 32'h1122_3344, 3, 2, 4'h0, 0, 32'h40, 0, 0, 0, 1, 32'h1122_3344);
    run_access(v, o);
    check_obs("after_rst", v, o);
    chk("after_rst load_data", o.ld, 32'h1122_3344);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 7'h03 : (sel < 8) ? 7'h23 : (sel == 8) ? 7'h13 : 7'h33;
      r   = $urandom_range(0, 9);
      v   = model(mk_inst(3'($urandom_range(0, 7)), op), $urandom, $urandom,
                  ($urandom_range(0, 3) != 0),
                  (r == 0) ? 0 : (r == 1) ? 17 : $urandom_range(1, TO), $urandom);
      if (v.exp_lv) exp_q.push_back(v.exp_ld);
      run_access(v, o);
      check_obs($sformatf("rnd%0d", i), v, o);
      if (o.lv && exp_q.size() > 0) chk($sformatf("rnd%0d load_data", i), o.ld, exp_q.pop_front());
    end
    chk("scoreboard drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
